addsub_acc_ctrl: RTL and testbench
==================================

# addsub_acc_ctrl

Accumulator and command sequencer for the 4-bit add/subtract datapath. It accepts LOAD/ADD/SUB/CLEAR commands over a valid/ready handshake and drives the datapath's operand and mode inputs from a registered accumulator. It captures the datapath sum and carry back into the accumulator and presents a flagged result on a second valid/ready handshake. The block wraps the combinational adder/subtractor and sits between the command source and the result consumer.

## Interface
- No parameters; data width fixed at 4 bits.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
- cmd_data  in  4  operand (ignored for CLEAR)
- as_a  out  4  datapath operand A
- as_b  out  4  datapath operand B
- as_mode  out  1  datapath mode, 0 add, 1 subtract
- as_sum  in  4  datapath sum
- as_cout  in  1  datapath carry out
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result
- res_data  out  4  result value (new accumulator)
- res_cout  out  1  carry out (ADD: carry; SUB: 1 = no borrow)
- res_zero  out  1  res_data == 0
- res_ovf  out  1  signed two's-complement overflow
- acc_out  out  4  current accumulator value

## Operation
- States: IDLE, EXEC, HOLD.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, register cmd_op and cmd_data, then go to EXEC.
- EXEC (exactly one cycle): drive the datapath combinationally from the registered values.
  - ADD: as_a=acc, as_b=data, as_mode=0.
  - SUB: as_a=acc, as_b=data, as_mode=1.
  - LOAD: as_a=0, as_b=data, as_mode=0.
  - CLEAR: as_a=0, as_b=0, as_mode=0.
- End of EXEC:
  - acc<=as_sum; res_data<=as_sum; res_cout<=as_cout.
  - res_zero<=(as_sum==0).
  - res_ovf: ADD = (a[3]==b[3])&&(sum[3]!=a[3]); SUB = (a[3]!=b[3])&&(sum[3]!=a[3]); LOAD/CLEAR = 0.
  - Force res_cout to 0 for LOAD/CLEAR.
  - Go to HOLD.
- HOLD: res_valid=1; all res_* held stable. On res_ready, go to IDLE.
- cmd_ready=0 in EXEC and HOLD. Only one command is ever in flight.
- as_a, as_b, as_mode are 0 outside EXEC.
- All arithmetic is modulo 16. No saturation. The accumulator wraps.
- The block performs no arithmetic beyond the overflow sign compare. The sum comes only from as_sum/as_cout.

## Timing
- Reset (async, immediate):
  - state=IDLE, acc=0, acc_out=0.
  - res_valid=0, res_data=0, res_cout=0, res_zero=0, res_ovf=0.
  - Registered op/data cleared.
  - cmd_ready=0 while rst is high; cmd_ready=1 from the first cycle after deassertion.
- Latency: command accepted at edge N; EXEC occupies cycle N..N+1; res_valid rises after edge N+1.
- Minimum command spacing is 3 cycles when res_ready is held high.
- Result transfer occurs on the edge where res_valid&&res_ready. res_valid falls after that edge; cmd_ready rises the same cycle.
- res_ready asserted during IDLE or EXEC has no effect.
- Backpressure: HOLD persists indefinitely; accumulator and outputs remain unchanged.
- Reset during EXEC or HOLD: the in-flight command is discarded, no result is produced, and the accumulator returns to 0.
- acc_out updates on the same edge that loads res_data.

## Test plan
- Reset, then LOAD 5, then ADD 3 -> res_data=8, cout=0, ovf=1, zero=0; res_valid 2 edges after each accept.
- With acc=8, SUB 8 -> res_data=0, cout=1, zero=1, ovf=0; then SUB 1 -> res_data=F, cout=0, ovf=0.
- LOAD 9, ADD 9 -> res_data=2, cout=1, ovf=1; then CLEAR -> res_data=0, zero=1, cout=0, acc_out=0.
- Hold res_ready=0 for 5 cycles after a result -> res_valid and res_* stable, cmd_ready=0, cmd_valid ignored; release -> transfer, then next command accepted.
- Assert rst in the EXEC cycle of ADD -> res_valid stays 0, acc_out=0; next LOAD 4 after reset completes normally with res_data=4.
- Back-to-back commands with cmd_valid and res_ready tied high -> one accept every 3 cycles, as_* outputs 0 except in EXEC.

Source files
------------

// File: rtl/addsub_acc_ctrl.sv
// Command sequencer and accumulator around an external 4-bit add/subtract datapath.
// Accepts one LOAD/ADD/SUB/CLEAR command at a time and returns a flagged result.
module addsub_acc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic [3:0] as_a,
  output logic [3:0] as_b,
  output logic       as_mode,
  input  logic [3:0] as_sum,
  input  logic       as_cout,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_cout,
  output logic       res_zero,
  output logic       res_ovf,
  output logic [3:0] acc_out,
  output logic [1:0] dbg_state_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;

  // Handshakes: a command transfers on the rising edge where cmd_valid && cmd_ready;
  // a result transfers on the rising edge where res_valid && res_ready.
  logic [1:0] state_q, state_d;
  logic [1:0] op_q;
  logic [3:0] data_q;
  logic [3:0] acc_q;
  logic [3:0] rdata_q;
  logic       rcout_q, rzero_q, rovf_q;
  logic       ovf_d, cout_d;

  always_comb begin
    as_a    = 4'd0;
    as_b    = 4'd0;
    as_mode = 1'b0;
    ovf_d   = 1'b0;
    cout_d  = 1'b0;
    if (state_q == EXEC) begin
      case (op_q)
        OP_ADD: begin
          as_a   = acc_q;
          as_b   = data_q;
          cout_d = as_cout;
          ovf_d  = (acc_q[3] == data_q[3]) && (as_sum[3] != acc_q[3]);
        end
        OP_SUB: begin
          as_a    = acc_q;
          as_b    = data_q;
          as_mode = 1'b1;
          cout_d  = as_cout;
          ovf_d   = (acc_q[3] != data_q[3]) && (as_sum[3] != acc_q[3]);
        end
        OP_LOAD: as_b = data_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      data_q  <= 4'd0;
      acc_q   <= 4'd0;
      rdata_q <= 4'd0;
      rcout_q <= 1'b0;
      rzero_q <= 1'b0;
      rovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_valid) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
      end
      if (state_q == EXEC) begin
        acc_q   <= as_sum;
        rdata_q <= as_sum;
        rcout_q <= cout_d;
        rzero_q <= (as_sum == 4'd0);
        rovf_q  <= ovf_d;
      end
    end
  end

  // Held low during reset so nothing is accepted while the block is being cleared.
  assign cmd_ready   = (state_q == IDLE) && !rst;
  assign res_valid   = (state_q == HOLD);
  assign res_data    = rdata_q;
  assign res_cout    = rcout_q;
  assign res_zero    = rzero_q;
  assign res_ovf     = rovf_q;
  assign acc_out     = acc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Directed bench for addsub_acc_ctrl with a behavioural datapath and an expected-result queue.
module tb_addsub_acc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] as_a, as_b, as_sum;
  logic       as_mode, as_cout;
  logic       res_valid, res_ready;
  logic [3:0] res_data, acc_out;
  logic       res_cout, res_zero, res_ovf;
  logic [1:0] dbg_state;
  logic [4:0] dp_full;

  localparam logic [1:0] OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_CLR = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_HOLD = 2'd2;

  int checks = 0;
  int errors = 0;
  logic [3:0] acc_m = 4'd0;
  logic [6:0] exp_q[$];

  addsub_acc_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .as_a(as_a), .as_b(as_b),
    .as_mode(as_mode), .as_sum(as_sum), .as_cout(as_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cout(res_cout), .res_zero(res_zero), .res_ovf(res_ovf),
    .acc_out(acc_out), .dbg_state_o(dbg_state)
  );

  // Combinational adder/subtractor that the block drives.
  assign dp_full = as_mode ? ({1'b0, as_a} + {1'b0, ~as_b} + 5'd1) : ({1'b0, as_a} + {1'b0, as_b});
  assign as_sum  = dp_full[3:0];
  assign as_cout = dp_full[4];

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sval(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  // Reference model: returns {ovf, zero, cout, sum} plus expected datapath drive, updates acc_m.
  task automatic model(input logic [1:0] op, input logic [3:0] d, output logic [6:0] e,
                       output logic [3:0] ea, output logic [3:0] eb, output logic em);
    logic [3:0] s;
    logic c, o;
    int r;
    ea = 4'd0; eb = 4'd0; em = 1'b0; s = 4'd0; c = 1'b0; o = 1'b0;
    case (op)
      OP_LOAD: begin eb = d; s = d; end
      OP_ADD: begin
        ea = acc_m; eb = d; s = acc_m + d;
        c = (int'(acc_m) + int'(d)) > 15;
        r = sval(acc_m) + sval(d); o = (r > 7) || (r < -8);
      end
      OP_SUB: begin
        ea = acc_m; eb = d; em = 1'b1; s = acc_m - d;
        c = (acc_m >= d);
        r = sval(acc_m) - sval(d); o = (r > 7) || (r < -8);
      end
      default: ;
    endcase
    e = {o, (s == 4'd0), c, s};
    acc_m = s;
  endtask

  // Called just after a negedge; returns just after the accepting posedge.
  task automatic accept_cmd(input logic [1:0] op, input logic [3:0] d);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        ok = 1;
      end else @(negedge clk);
    end
    if (!ok) check("accept_timeout", 8'd0, 8'd1);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, input int hold, input bit early);
    logic [6:0] e, got;
    logic [3:0] ea, eb;
    logic em;
    model(op, d, e, ea, eb, em);
    exp_q.push_back(e);
    accept_cmd(op, d);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (early) res_ready = 1'b1;
    check("exec_state", 8'(dbg_state), 8'(S_EXEC));
    check("exec_res_valid", 8'(res_valid), 8'd0);
    check("exec_cmd_ready", 8'(cmd_ready), 8'd0);
    check("exec_as", {as_mode, as_a, 3'b0}, {em, ea, 3'b0});
    check("exec_as_b", 8'(as_b), 8'(eb));
    @(negedge clk);
    check("latency_res_valid", 8'(res_valid), 8'd1);
    got = exp_q.pop_front();
    check("result", 8'({res_ovf, res_zero, res_cout, res_data}), 8'(got));
    check("acc_out", 8'(acc_out), 8'(got[3:0]));
    check("hold_as_zero", {as_mode, as_a, as_b[2:0]}, 8'd0);
    res_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 4'd7;
      @(negedge clk);
      check("hold_stable", 8'({res_valid, res_ovf, res_zero, res_cout, res_data}), 8'({1'b1, got}));
      check("hold_cmd_ready", 8'(cmd_ready), 8'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_xfer_res_valid", 8'(res_valid), 8'd0);
    check("post_xfer_cmd_ready", 8'(cmd_ready), 8'd1);
  endtask

  initial begin
    logic [6:0] e, got;
    logic [3:0] ea, eb;
    logic em;
    logic [1:0] b2b_op[4];
    logic [3:0] b2b_d[4];
    int n;
    b2b_op = '{OP_LOAD, OP_ADD, OP_SUB, OP_ADD};
    b2b_d  = '{4'd3, 4'd4, 4'd2, 4'hF};
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 4'd0; res_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 8'(cmd_ready), 8'd0);
    check("rst_res", 8'({res_valid, res_ovf, res_zero, res_cout, res_data}), 8'd0);
    check("rst_acc", 8'(acc_out), 8'd0);
    check("rst_state", 8'(dbg_state), 8'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 8'(cmd_ready), 8'd1);

    do_cmd(OP_LOAD, 4'd5, 0, 0);
    do_cmd(OP_ADD,  4'd3, 0, 0);   // 8, ovf
    do_cmd(OP_SUB,  4'd8, 0, 0);   // 0, zero, no borrow
    do_cmd(OP_SUB,  4'd1, 0, 1);   // F, borrow; res_ready early has no effect
    do_cmd(OP_LOAD, 4'd9, 0, 0);
    do_cmd(OP_ADD,  4'd9, 0, 0);   // 2, carry, ovf
    do_cmd(OP_CLR,  4'd6, 0, 0);
    do_cmd(OP_ADD,  4'd6, 5, 0);   // backpressure for 5 cycles
    do_cmd(OP_LOAD, 4'd2, 0, 0);

    // Reset during EXEC discards the in-flight ADD
    accept_cmd(OP_ADD, 4'd5);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_acc", 8'(acc_out), 8'd0);
    check("midrst_res_valid", 8'(res_valid), 8'd0);
    check("midrst_cmd_ready", 8'(cmd_ready), 8'd0);
    check("midrst_as", {as_mode, as_a, as_b[2:0]}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    acc_m = 4'd0;
    @(negedge clk);
    check("after_midrst", 8'({cmd_ready, res_valid, 2'b0, acc_out}), 8'h80);
    do_cmd(OP_LOAD, 4'd4, 0, 0);

    // Back-to-back with cmd_valid and res_ready held high
    res_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        check("b2b_spacing", 8'(i % 3), 8'd0);
        if (n < 4) begin
          cmd_valid = 1'b1; cmd_op = b2b_op[n]; cmd_data = b2b_d[n];
          model(b2b_op[n], b2b_d[n], e, ea, eb, em);
          exp_q.push_back(e);
          n++;
        end
      end
      if (res_valid) begin
        got = exp_q.pop_front();
        check("b2b_result", 8'({res_ovf, res_zero, res_cout, res_data}), 8'(got));
      end
      if (dbg_state != S_EXEC)
        check("b2b_as_idle", {as_mode, as_a, as_b[2:0]}, 8'd0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    check("b2b_accepts", 8'(n), 8'd4);
    check("queue_empty", 8'(exp_q.size()), 8'd0);
    check("final_acc", 8'(acc_out), 8'(acc_m));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
